// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Purpose:
//   Shares the single RAMblock port between two masters.
//     m0 : CU fetch/execute path
//     m1 : program loader / debug port (preloads RAM before the CU runs and
//          pokes it at run time)
//   Only one transaction is in flight at a time. Each transaction goes
//   IDLE (grant) -> ACCESS (RAM strobes held ACCESS_CYCLES cycles) ->
//   ACK (one-cycle ack pulse to the winner) -> IDLE.
//   Contention is resolved round-robin. m1_lock keeps m0 from being granted
//   so the loader has the RAM to itself during bulk program loads.
//
// Parameters:
//   ADDR_W         RAM address width
//   DATA_W         RAM data width
//   ACCESS_CYCLES  cycles the read/write strobe is held per transaction (>=1)
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   m0_req/m0_we/m0_addr/m0_wdata   m0 request (level), write enable, address, write data
//   m0_ack/m0_rdata                 m0 completion pulse and read data (valid from ack on)
//   m1_*                            same set for m1
//   m1_lock                         1 = m0 is never granted (sampled only while idle)
//   ram_address/ram_datain          address and write data towards RAMblock
//   ram_dataout                     read data from RAMblock
//   ram_read/ram_write              RAMblock strobes, only ever high during ACCESS
//   owner                           master of the current / most recent transaction
//   busy                            high during ACCESS and ACK
//
// Latency: a request sampled in IDLE cycle T drives the strobes in cycles
// T+1 .. T+ACCESS_CYCLES and acks in cycle T+ACCESS_CYCLES+1.
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    input  logic              m1_lock,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout,
    output logic              ram_read,
    output logic              ram_write,

    output logic              owner,
    output logic              busy
);

    // The counter has to hold ACCESS_CYCLES itself (it increments on the last
    // access cycle as well), hence the +1 in the width calculation.
    localparam int CNT_W = (ACCESS_CYCLES < 2) ? 1 : $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic                last_owner;
    logic [CNT_W-1:0]    access_cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    logic                m0_eligible;
    logic                m1_eligible;
    logic                grant_valid;
    logic                grant_sel;
    logic                access_done;

    // Arbitration: m1_lock masks m0 entirely. On a tie the master that did
    // not win last time gets the port; last_owner resets to 1 so m0 wins the
    // very first tie.
    always_comb begin
        m0_eligible = m0_req & ~m1_lock;
        m1_eligible = m1_req;
        grant_valid = m0_eligible | m1_eligible;
        grant_sel   = (m0_eligible & m1_eligible) ? ~last_owner : m1_eligible;
        access_done = (state == ACCESS) && (access_cnt == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all port-facing outputs. The RAM bus is zero whenever
    // the arbiter is not in ACCESS so the RAMblock never sees stale strobes.
    always_comb begin
        state_next  = state;
        ram_address = '0;
        ram_datain  = '0;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        m0_ack      = 1'b0;
        m1_ack      = 1'b0;
        busy        = 1'b0;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end

            ACCESS: begin
                busy        = 1'b1;
                ram_address = lat_addr;
                ram_read    = ~lat_we;
                ram_write   = lat_we;
                ram_datain  = lat_we ? lat_wdata : '0;
                if (access_done) begin
                    state_next = ACK;
                end
            end

            ACK: begin
                busy       = 1'b1;
                m0_ack     = ~owner;
                m1_ack     = owner;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction datapath: latches the winner's request on grant so the
    // masters' inputs are ignored for the rest of the transaction, counts
    // access cycles and captures read data on the edge that ends the last
    // access cycle. Each master has its own read data register, which only
    // changes when that master completes a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            access_cnt <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_sel;
                        last_owner <= grant_sel;
                        access_cnt <= '0;
                        lat_we     <= grant_sel ? m1_we    : m0_we;
                        lat_addr   <= grant_sel ? m1_addr  : m0_addr;
                        lat_wdata  <= grant_sel ? m1_wdata : m0_wdata;
                    end
                end

                ACCESS: begin
                    access_cnt <= access_cnt + CNT_W'(1);
                    if (access_done && !lat_we) begin
                        if (owner) begin
                            rdata1_q <= ram_dataout;
                        end else begin
                            rdata0_q <= ram_dataout;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Drives ram_port_arbiter against a small behavioural RAM. A directed table
// walks through reset, single reads/writes and tie alternation cycle by cycle;
// hand-written sequences cover m1_lock and reset in the middle of a write;
// a randomized phase compares every cycle against a transaction-timeline
// reference model.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int AC     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m0_we, m0_ack;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_ack;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              m1_lock;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_datain, ram_dataout;
    logic              ram_read, ram_write, owner, busy;

    ram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(AC)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .m1_lock(m1_lock),
        .ram_address(ram_address), .ram_datain(ram_datain), .ram_dataout(ram_dataout),
        .ram_read(ram_read), .ram_write(ram_write),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAMblock stand-in: combinational read, write on the rising edge.
    logic [DATA_W-1:0] ram [256];
    assign ram_dataout = ram[ram_address];
    always @(posedge clk) begin
        if (ram_write) ram[ram_address] <= ram_datain;
    end

    typedef struct packed {
        logic rst; logic r0; logic w0; logic [7:0] a0; logic [7:0] d0;
        logic r1; logic w1; logic [7:0] a1; logic [7:0] d1; logic lk;
    } in_t;

    typedef struct packed {
        logic [7:0] addr; logic [7:0] din;
        logic rd; logic wr; logic ack0; logic ack1; logic own; logic busy;
        logic [7:0] rd0; logic [7:0] rd1;
    } out_t;

    typedef struct packed { in_t stim; out_t exp; } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    out_t act;
    logic mack0, mack1;

    // Reference model: a transaction timeline. ph = 0 idle, 1..AC strobe
    // cycles, AC+1 ack cycle. mem mirrors what the RAM should contain.
    int         ph = 0;
    logic       mo, ml, t_we;
    logic [7:0] t_addr, t_wdata;
    logic [7:0] mrd [2];
    logic [7:0] mem [256];

    function automatic in_t mkIn(logic rst, logic [1:0] rw0, logic [7:0] a0, logic [7:0] d0,
                                 logic [1:0] rw1, logic [7:0] a1, logic [7:0] d1, logic lk);
        in_t s;
        s.rst = rst; s.r0 = rw0[1]; s.w0 = rw0[0]; s.a0 = a0; s.d0 = d0;
        s.r1 = rw1[1]; s.w1 = rw1[0]; s.a1 = a1; s.d1 = d1; s.lk = lk;
        return s;
    endfunction

    // flags = {rd, wr, ack0, ack1, own, busy}
    function automatic out_t mkOut(logic [7:0] addr, logic [7:0] din, logic [5:0] flags,
                                   logic [7:0] rd0, logic [7:0] rd1);
        out_t o;
        o.addr = addr; o.din = din;
        {o.rd, o.wr, o.ack0, o.ack1, o.own, o.busy} = flags;
        o.rd0 = rd0; o.rd1 = rd1;
        return o;
    endfunction

    task automatic addRows(input int n, input in_t s, input out_t e);
        vec_t v;
        v.stim = s; v.exp = e;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    function automatic string fmt(out_t o);
        return $sformatf("addr=%h din=%h rd=%b wr=%b ack0=%b ack1=%b own=%b busy=%b rd0=%h rd1=%h",
                         o.addr, o.din, o.rd, o.wr, o.ack0, o.ack1, o.own, o.busy, o.rd0, o.rd1);
    endfunction

    function automatic out_t actualOut();
        out_t o;
        o.addr = ram_address; o.din = ram_datain; o.rd = ram_read; o.wr = ram_write;
        o.ack0 = m0_ack; o.ack1 = m1_ack; o.own = owner; o.busy = busy;
        o.rd0 = m0_rdata; o.rd1 = m1_rdata;
        return o;
    endfunction

    function automatic out_t modelOut();
        out_t o;
        o = '0;
        o.rd0 = mrd[0]; o.rd1 = mrd[1]; o.own = mo;
        if (ph >= 1 && ph <= AC) begin
            o.busy = 1'b1; o.addr = t_addr; o.rd = ~t_we; o.wr = t_we;
            o.din = t_we ? t_wdata : 8'h00;
        end else if (ph == AC + 1) begin
            o.busy = 1'b1; o.ack0 = ~mo; o.ack1 = mo;
        end
        return o;
    endfunction

    // Advance the model across one rising edge using the inputs of the cycle
    // that just ended. The RAM keeps any write strobed in that cycle even if
    // reset is asserted, so the memory update comes first.
    task automatic modelStep();
        logic e0, e1, win;
        if (ph >= 1 && ph <= AC && t_we) mem[t_addr] = t_wdata;
        if (reset) begin
            ph = 0; mo = 1'b0; ml = 1'b1; mrd[0] = 8'h00; mrd[1] = 8'h00;
        end else if (ph == 0) begin
            e0 = m0_req & ~m1_lock;
            e1 = m1_req;
            if (e0 | e1) begin
                win     = (e0 & e1) ? ~ml : e1;
                mo      = win; ml = win;
                t_we    = win ? m1_we    : m0_we;
                t_addr  = win ? m1_addr  : m0_addr;
                t_wdata = win ? m1_wdata : m0_wdata;
                ph      = 1;
            end
        end else if (ph <= AC) begin
            if (ph == AC && !t_we) mrd[mo] = mem[t_addr];
            ph = ph + 1;
        end else begin
            ph = 0;
        end
    endtask

    task automatic applyStimulus(input in_t s);
        reset = s.rst;
        m0_req = s.r0; m0_we = s.w0; m0_addr = s.a0; m0_wdata = s.d0;
        m1_req = s.r1; m1_we = s.w1; m1_addr = s.a1; m1_wdata = s.d1;
        m1_lock = s.lk;
    endtask

    task automatic checkOutput(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got {%s} expected {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock cycle: sample outputs on the falling edge, compare against
    // the table entry or the model, then move the model across the next rising edge.
    task automatic runCycle(input string name, input bit use_table, input out_t tab_exp);
        out_t m;
        @(negedge clk);
        act   = actualOut();
        m     = modelOut();
        mack0 = m.ack0;
        mack1 = m.ack1;
        checkOutput(name, act, use_table ? tab_exp : m);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Random master behaviour: hold a request until its ack, then either
    // issue a new one straight away or go quiet.
    task automatic driveRandom();
        if (!m0_req || mack0) begin
            m0_req   = ($urandom_range(0, 3) != 0);
            m0_we    = 1'($urandom_range(0, 1));
            m0_addr  = 8'h10 + 8'($urandom_range(0, 7));
            m0_wdata = 8'($urandom);
        end
        if (!m1_req || mack1) begin
            m1_req   = ($urandom_range(0, 3) != 0);
            m1_we    = 1'($urandom_range(0, 1));
            m1_addr  = 8'h10 + 8'($urandom_range(0, 7));
            m1_wdata = 8'($urandom);
        end
        if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;
        reset = ($urandom_range(0, 79) == 0);
    endtask

    initial begin
        in_t  none_rst, none;
        out_t zero;
        int   c0, c1;
        bit   seen;

        for (int a = 0; a < 256; a++) begin
            ram[a] = 8'(a) ^ 8'h5A;
            mem[a] = 8'(a) ^ 8'h5A;
        end
        ram[8'h10] = 8'h05;
        mem[8'h10] = 8'h05;
        mrd[0] = 8'h00; mrd[1] = 8'h00;

        none_rst = mkIn(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0);
        none     = mkIn(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0);
        zero     = '0;

        // Reset, m0 read 0x10 (RAM holds 5)
        addRows(1, none_rst, zero);
        addRows(1, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0), zero);
        addRows(2, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0),
                   mkOut(8'h10, 8'h00, 6'b100001, 8'h00, 8'h00));
        addRows(1, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b001001, 8'h05, 8'h00));
        // m1 read 0x10
        addRows(1, mkIn(1'b0, 2'b00, 8'h00, 8'h00, 2'b10, 8'h10, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b000000, 8'h05, 8'h00));
        addRows(2, mkIn(1'b0, 2'b00, 8'h00, 8'h00, 2'b10, 8'h10, 8'h00, 1'b0),
                   mkOut(8'h10, 8'h00, 6'b100011, 8'h05, 8'h00));
        addRows(1, mkIn(1'b0, 2'b00, 8'h00, 8'h00, 2'b10, 8'h10, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b000111, 8'h05, 8'h05));
        // m1 write 0x11 <= 2
        addRows(1, mkIn(1'b0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h11, 8'h02, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b000010, 8'h05, 8'h05));
        addRows(2, mkIn(1'b0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h11, 8'h02, 1'b0),
                   mkOut(8'h11, 8'h02, 6'b010011, 8'h05, 8'h05));
        addRows(1, mkIn(1'b0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h11, 8'h02, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b000111, 8'h05, 8'h05));
        // m0 read 0x11 -> 2, m1_rdata stays 5
        addRows(1, mkIn(1'b0, 2'b10, 8'h11, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b000010, 8'h05, 8'h05));
        addRows(2, mkIn(1'b0, 2'b10, 8'h11, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0),
                   mkOut(8'h11, 8'h00, 6'b100001, 8'h05, 8'h05));
        addRows(1, mkIn(1'b0, 2'b10, 8'h11, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b001001, 8'h02, 8'h05));
        // Reset, then both request: m0, m1, m0
        addRows(1, none_rst, mkOut(8'h00, 8'h00, 6'b000000, 8'h02, 8'h05));
        addRows(1, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0), zero);
        addRows(2, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0),
                   mkOut(8'h10, 8'h00, 6'b100001, 8'h00, 8'h00));
        addRows(1, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b001001, 8'h05, 8'h00));
        addRows(1, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b000000, 8'h05, 8'h00));
        addRows(2, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0),
                   mkOut(8'h11, 8'h00, 6'b100011, 8'h05, 8'h00));
        addRows(1, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b000111, 8'h05, 8'h02));
        addRows(1, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b000010, 8'h05, 8'h02));
        addRows(2, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0),
                   mkOut(8'h10, 8'h00, 6'b100001, 8'h05, 8'h02));
        addRows(1, mkIn(1'b0, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b0),
                   mkOut(8'h00, 8'h00, 6'b001001, 8'h05, 8'h02));

        $display("[TB] start, %0d table vectors", vecs.size());
        applyStimulus(none_rst);
        @(posedge clk);
        modelStep();
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stim);
            runCycle($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
        end

        // m1_lock: only m1 is served; m0 follows once the lock drops
        applyStimulus(mkIn(1'b1, 2'b10, 8'h10, 8'h00, 2'b10, 8'h11, 8'h00, 1'b1));
        runCycle("lock_reset", 1'b0, zero);
        reset = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 12; i++) begin
            runCycle($sformatf("lock%0d", i), 1'b0, zero);
            c0 += int'(act.ack0);
            c1 += int'(act.ack1);
        end
        checkValue("lock_m0_acks", c0, 0);
        checkValue("lock_m1_acks", c1, 3);
        m1_lock = 1'b0;
        m1_req  = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            runCycle($sformatf("unlock%0d", i), 1'b0, zero);
            seen = act.ack0;
        end
        checkValue("unlock_m0_ack", int'(seen), 1);

        // Reset in the first strobe cycle of an m0 write
        applyStimulus(none_rst);
        runCycle("wrst_reset", 1'b0, zero);
        applyStimulus(mkIn(1'b0, 2'b11, 8'h12, 8'h77, 2'b00, 8'h00, 8'h00, 1'b0));
        runCycle("wrst_grant", 1'b0, zero);
        reset = 1'b1;
        runCycle("wrst_access", 1'b0, zero);
        checkValue("wrst_write_active", int'(act.wr), 1);
        applyStimulus(none);
        runCycle("wrst_after", 1'b0, zero);
        checkValue("wrst_write_low", int'(act.wr), 0);
        checkValue("wrst_busy_low", int'(act.busy), 0);
        checkValue("wrst_no_ack", int'(act.ack0), 0);
        runCycle("wrst_idle", 1'b0, zero);
        checkValue("wrst_no_late_ack", int'(act.ack0 | act.ack1), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            driveRandom();
            runCycle($sformatf("rand%0d", i), 1'b0, zero);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
